// File: rtl/adder_result_fifo.sv
// Show-ahead result FIFO behind the datapath adder: buffers sum + equal/less flags
// for a stalling consumer and keeps a saturating count of zero results.
module adder_result_fifo #(
    parameter int GOLOBAL_DATA_BUS_WIDTH = 32,
    parameter int DEPTH                  = 4,
    parameter int CNT_WIDTH              = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [GOLOBAL_DATA_BUS_WIDTH-1:0] in_sum,
    input  logic                              in_equal,
    input  logic                              in_less,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [GOLOBAL_DATA_BUS_WIDTH-1:0] out_sum,
    output logic                              out_equal,
    output logic                              out_less,
    output logic [$clog2(DEPTH):0]            occupancy,
    output logic [CNT_WIDTH-1:0]              zero_count,
    input  logic                              clear_stats
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [GOLOBAL_DATA_BUS_WIDTH-1:0] sum;
        logic                              equal;
        logic                              less;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          live;
    logic          push, pop;

    // live holds in_ready low until the first clock after reset release
    assign in_ready  = live && (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign occupancy = count;

    // Head is forced to zero when empty so outputs read 0 during/after reset
    assign head      = out_valid ? mem[rd_ptr] : '0;
    assign out_sum   = head.sum;
    assign out_equal = head.equal;
    assign out_less  = head.less;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live   <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            live <= 1'b1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_sum, in_equal, in_less};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_count <= '0;
        end else if (clear_stats) begin
            zero_count <= '0;
        end else if (push && in_equal && zero_count != CNT_MAX) begin
            zero_count <= zero_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_adder_result_fifo.sv
// Bench for adder_result_fifo: directed + random stimulus, queue-based reference model
// checked by an independent negedge monitor.
module tb_adder_result_fifo;
    localparam int W = 32;
    localparam int DEPTH = 4;

    logic clk, rst_n;
    logic in_valid, in_ready, in_equal, in_less;
    logic [W-1:0] in_sum, out_sum;
    logic out_valid, out_ready, out_equal, out_less, clear_stats;
    logic [2:0] occupancy;
    logic [15:0] zero_count;
    // Second instance with a tiny counter exercises saturation on the same traffic
    logic s_in_ready, s_out_valid, s_out_equal, s_out_less;
    logic [W-1:0] s_out_sum;
    logic [2:0] s_occupancy;
    logic [1:0] s_zero_count;

    adder_result_fifo #(.GOLOBAL_DATA_BUS_WIDTH(W), .DEPTH(DEPTH), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_equal(in_equal), .in_less(in_less),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_equal(out_equal), .out_less(out_less), .occupancy(occupancy),
        .zero_count(zero_count), .clear_stats(clear_stats));

    adder_result_fifo #(.GOLOBAL_DATA_BUS_WIDTH(W), .DEPTH(DEPTH), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_sum(in_sum), .in_equal(in_equal), .in_less(in_less),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_sum(s_out_sum),
        .out_equal(s_out_equal), .out_less(s_out_less), .occupancy(s_occupancy),
        .zero_count(s_zero_count), .clear_stats(clear_stats));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         e;
        logic         l;
    } exp_t;

    exp_t q[$];
    int   zc, zc2;
    bit   live;
    int   vectors = 0;
    int   errors  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor/model: inputs change only at posedge+1, so negedge values are what the next edge sees
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete(); zc = 0; zc2 = 0; live = 0;
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_occupancy", occupancy, 0);
            chk("rst_zero_count", zero_count, 0);
            chk("rst_out_fields", {out_sum, out_equal, out_less}, 0);
        end else begin
            bit push, pop;
            chk("in_ready", in_ready, live && q.size() < DEPTH);
            chk("out_valid", out_valid, q.size() != 0);
            chk("occupancy", occupancy, q.size());
            chk("zero_count", zero_count, zc);
            chk("sat_zero_count", s_zero_count, zc2);
            if (q.size() != 0) begin
                chk("out_sum", out_sum, q[0].s);
                chk("out_flags", {out_equal, out_less}, {q[0].e, q[0].l});
            end
            push = in_valid && live && q.size() < DEPTH;
            pop  = out_ready && q.size() != 0;
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{s: in_sum, e: in_equal, l: in_less});
            if (clear_stats) begin
                zc = 0; zc2 = 0;
            end else if (push && in_equal) begin
                if (zc < 65535) zc++;
                if (zc2 < 3) zc2++;
            end
            live = 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] s, input logic e, input logic l);
        in_valid = v; in_sum = s; in_equal = e; in_less = l;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        logic [W-1:0] r;
        rst_n = 0; drive(0, 0, 0, 0); out_ready = 0; clear_stats = 0;
        repeat (3) step();
        rst_n = 1;
        step();

        // single push then pop
        drive(1, 32'h5, 0, 1); step();
        drive(0, 0, 0, 0); step();
        out_ready = 1; step();
        out_ready = 0; step();

        // fill to full, hold 9 while full, then drain
        for (int i = 1; i <= 4; i++) begin
            drive(1, W'(i), 0, 1); step();
        end
        drive(1, 32'h9, 0, 1);
        repeat (2) step();
        out_ready = 1;
        k = 0;
        while (!in_ready && k < 20) begin step(); k++; end
        if (k >= 20) begin
            vectors++; errors++;
            $display("FAIL full_release: in_ready stayed 0, expected 1");
        end
        step();
        drive(0, 0, 0, 0);
        repeat (6) step();

        // streaming 0..19 with push and pop every cycle
        for (int i = 0; i < 20; i++) begin
            drive(1, W'(i), i == 0, i != 0); step();
        end
        drive(0, 0, 0, 0);
        repeat (3) step();

        // zero counting, clear precedence, saturation on the 2-bit instance
        for (int i = 0; i < 3; i++) begin drive(1, 0, 1, 0); step(); end
        drive(1, 0, 1, 0); clear_stats = 1; step();
        clear_stats = 0;
        for (int i = 0; i < 5; i++) begin drive(1, 0, 1, 0); step(); end
        drive(0, 0, 0, 0);
        repeat (3) step();

        // async reset with 3 entries queued, checked before any clock edge
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin drive(1, 32'hA0 + W'(i), 1, 0); step(); end
        drive(0, 0, 0, 0);
        #2 rst_n = 0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_occupancy", occupancy, 0);
        chk("async_zero_count", zero_count, 0);
        chk("async_in_ready", in_ready, 0);
        repeat (2) step();
        rst_n = 1;
        step();
        drive(1, 32'h77, 0, 1); step();
        drive(0, 0, 0, 0); out_ready = 1; step();
        out_ready = 0;

        // stall: head must hold while producer toggles
        drive(1, 32'hDEAD_BEEF, 1, 1); step();
        for (int i = 0; i < 5; i++) begin
            r = $urandom;
            drive(i[0], r, r[0], r[1]); step();
        end
        drive(0, 0, 0, 0); out_ready = 1;
        repeat (6) step();

        // randomized traffic, flags independent of sum
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            drive($urandom_range(0, 3) != 0, ($urandom_range(0, 3) == 0) ? '0 : r,
                  $urandom_range(0, 1), $urandom_range(0, 1));
            out_ready = $urandom_range(0, 2) != 0;
            clear_stats = $urandom_range(0, 30) == 0;
            step();
        end
        drive(0, 0, 0, 0); clear_stats = 0; out_ready = 1;
        repeat (8) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
